approx_mul_share_ctrl: RTL and testbench

//  Time-shares one 8x8 unsigned approximate multiplier core (Dadda tree + ripple final adder)

---
 rtl/approx_mul_share_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_approx_mul_share_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_share_ctrl.sv
// approx_mul_share_ctrl
//   Shares a single external W x W multiplier core among NREQ requesters.
//   A round-robin arbiter grants at most one requester per cycle, the granted
//   operands are registered onto the core inputs, and the requester id travels
//   alongside the operation through a tag pipe matching the core latency. When
//   the tag reaches the end of the pipe the core product is captured into a
//   small result FIFO that is drained with valid/ready handshaking. Grants are
//   credit-limited by the number of accepted-but-not-yet-popped operations, so
//   the FIFO can never overflow and acceptance never depends on rsp_ready.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset (synchronous release expected)
//   req_valid  per-requester operand valid
//   req_ready  per-requester accept, at most one bit high
//   req_a/b    packed operands, slice i belongs to requester i
//   mul_a/b    registered operands driven to the multiplier core
//   mul_p      product returned by the core MUL_LAT cycles after mul_a/mul_b
//   rsp_valid  result FIFO head valid
//   rsp_ready  consumer accepts the head result
//   rsp_id     requester index of the head result
//   rsp_p      product of the head result
//   busy       at least one accepted operation not yet popped
//   op_count   free-running count of accepted operations (wraps)

module approx_mul_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int MUL_LAT = 0,
  parameter int IDW     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic [W-1:0]        mul_a,
  output logic [W-1:0]        mul_b,
  input  logic [2*W-1:0]      mul_p,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*W-1:0]      rsp_p,
  output logic                busy,
  output logic [15:0]         op_count
);

  localparam int DEPTH = MUL_LAT + 3;
  localparam int PW    = 2 * W;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PTRW  = $clog2(DEPTH);

  // Control state
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [15:0]     op_count_q, op_count_d;
  logic [W-1:0]    mul_a_q, mul_b_q;
  logic [MUL_LAT:0] vld_q;
  logic [IDW-1:0]  id_q [0:MUL_LAT];

  // Result FIFO
  logic [IDW-1:0]  mem_id_q [0:DEPTH-1];
  logic [PW-1:0]   mem_p_q  [0:DEPTH-1];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Arbitration results
  logic            found;
  logic [IDW-1:0]  grant;
  logic [W-1:0]    sel_a, sel_b;
  logic            credit;
  logic            accept;
  logic            push;
  logic            pop;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // Round-robin search: first pass covers rr_ptr..NREQ-1, second pass wraps
  // around to 0..rr_ptr-1, so the lowest index at or after rr_ptr wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (IDW'(i) >= rr_ptr_q)) begin
        found = 1'b1;
        grant = IDW'(i);
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (IDW'(i) < rr_ptr_q)) begin
        found = 1'b1;
        grant = IDW'(i);
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  // Credits are judged on registered occupancy only, keeping rsp_ready out
  // of the req_ready path.
  assign credit = (occ_q < CW'(DEPTH));
  assign accept = found && credit;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (grant == IDW'(i));
    end
  end

  assign push = vld_q[MUL_LAT];
  assign pop  = (cnt_q != '0) && rsp_ready;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    op_count_d = op_count_q;
    if (accept) begin
      rr_ptr_d   = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
      op_count_d = op_count_q + 16'd1;
    end

    occ_d = occ_q;
    case ({accept, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase

    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  // Issue stage, tag-valid pipe, FIFO capture. FIFO storage is cleared on
  // reset so the head outputs read as zero while the FIFO is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      occ_q      <= '0;
      op_count_q <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      vld_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_id_q[k] <= '0;
        mem_p_q[k]  <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      occ_q      <= occ_d;
      op_count_q <= op_count_d;
      if (accept) begin
        mul_a_q <= sel_a;
        mul_b_q <= sel_b;
      end
      vld_q[0] <= accept;
      for (int k = 1; k <= MUL_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      if (push) begin
        mem_id_q[wr_ptr_q] <= id_q[MUL_LAT];
        mem_p_q[wr_ptr_q]  <= mul_p;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Requester ids ride along with the valids; their validity is governed by
  // vld_q, so they need no reset.
  always_ff @(posedge clk) begin
    id_q[0] <= grant;
    for (int k = 1; k <= MUL_LAT; k++) begin
      id_q[k] <= id_q[k-1];
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = (cnt_q != '0);
  assign rsp_id    = mem_id_q[rd_ptr_q];
  assign rsp_p     = mem_p_q[rd_ptr_q];
  assign busy      = (occ_q != '0);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_approx_mul_share_ctrl.sv
module tb_approx_mul_share_ctrl;

  localparam int NREQ  = 4;
  localparam int W     = 8;
  localparam int IDW   = 3;
  localparam int DEPTH = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance, combinational core
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0]      mul_a, mul_b;
  logic [2*W-1:0]    mul_p;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_p;
  logic              busy;
  logic [15:0]       op_count;

  assign mul_p = 16'(mul_a) * 16'(mul_b);

  approx_mul_share_ctrl #(.NREQ(NREQ), .W(W), .MUL_LAT(0), .IDW(IDW)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p),
    .busy(busy), .op_count(op_count)
  );

  // Second instance, two-cycle core
  logic [NREQ-1:0]   req_valid2, req_ready2;
  logic [NREQ*W-1:0] req_a2, req_b2;
  logic [W-1:0]      mul_a2, mul_b2;
  logic [2*W-1:0]    mul_p2, p2_d1, p2_d2;
  logic              rsp_valid2, rsp_ready2;
  logic [IDW-1:0]    rsp_id2;
  logic [2*W-1:0]    rsp_p2;
  logic              busy2;
  logic [15:0]       op_count2;

  always @(posedge clk) begin
    p2_d1 <= 16'(mul_a2) * 16'(mul_b2);
    p2_d2 <= p2_d1;
  end
  assign mul_p2 = p2_d2;

  approx_mul_share_ctrl #(.NREQ(NREQ), .W(W), .MUL_LAT(2), .IDW(IDW)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_a(req_a2), .req_b(req_b2),
    .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_id(rsp_id2), .rsp_p(rsp_p2),
    .busy(busy2), .op_count(op_count2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: a queue of outstanding results in acceptance
  // order, each with the cycle from which it may be presented.
  typedef struct {
    int id;
    int p;
    int due;
  } ent_t;

  ent_t q[$];
  int   rr = 0;
  int   last_a = 0, last_b = 0;
  int   opc = 0;
  int   ncyc = 0;
  int   g, mi;
  logic [NREQ-1:0] exp_ready;
  logic exp_v;
  ent_t e;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      rr = 0; last_a = 0; last_b = 0; opc = 0;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_p", 32'(rsp_p), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_op_count", 32'(op_count), 0);
      chk("rst_mul_a", 32'(mul_a), 0);
      chk("rst_mul_b", 32'(mul_b), 0);
    end else begin
      g = -1;
      if (q.size() < DEPTH) begin
        for (int k = 0; k < NREQ; k++) begin
          mi = (rr + k) % NREQ;
          if (g < 0 && req_valid[mi]) g = mi;
        end
      end
      exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
      exp_v = (q.size() > 0) && (q[0].due <= ncyc);

      chk("m_req_ready", 32'(req_ready), 32'(exp_ready));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v) begin
        chk("m_rsp_id", 32'(rsp_id), q[0].id);
        chk("m_rsp_p", 32'(rsp_p), q[0].p);
      end
      chk("m_busy", 32'(busy), 32'(q.size() != 0));
      chk("m_op_count", 32'(op_count), opc);
      chk("m_mul_a", 32'(mul_a), last_a);
      chk("m_mul_b", 32'(mul_b), last_b);

      if (exp_v && rsp_ready) void'(q.pop_front());
      if (g >= 0) begin
        last_a = int'(req_a[g*W +: W]);
        last_b = int'(req_b[g*W +: W]);
        e.id = g; e.p = last_a * last_b; e.due = ncyc + 2;
        q.push_back(e);
        rr = (g + 1) % NREQ;
        opc = (opc + 1) % 65536;
      end
    end
    ncyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
  endtask

  int nacc;

  initial begin
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    req_valid2 = '0; req_a2 = '0; req_b2 = '0; rsp_ready2 = 1'b1;
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Single op from requester 0: 0x0F * 0x11 = 0x00FF
    req_valid = 4'b0001;
    req_a[7:0] = 8'h0F; req_b[7:0] = 8'h11;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_no_early", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_id", 32'(rsp_id), 0);
    chk("t1_rsp_p", 32'(rsp_p), 32'h00FF);
    chk("t1_op_count", 32'(op_count), 1);

    // Two-cycle core: 0xFF * 0xFF from requester 2 appears 4 cycles later
    tick();
    req_valid2 = 4'b0100;
    req_a2[23:16] = 8'hFF; req_b2[23:16] = 8'hFF;
    @(negedge clk);
    chk("t4_ready", 32'(req_ready2), 32'h4);
    tick();
    req_valid2 = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("t4_rsp_valid", 32'(rsp_valid2), 32'(k == 4));
      if (k == 4) begin
        chk("t4_rsp_id", 32'(rsp_id2), 2);
        chk("t4_rsp_p", 32'(rsp_p2), 32'hFE01);
      end
    end

    // All requesters valid: grants rotate from rr=1, no bubbles once flowing
    tick();
    req_valid = 4'hF;
    rand_ops();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("t2_grant", 32'(req_ready), 32'(1 << ((1 + k) % 4)));
      if (k >= 2) chk("t2_no_bubble", 32'(rsp_valid), 1);
      tick();
      rand_ops();
    end

    // Backpressure: exactly DEPTH accepts, then drain ids 1,1,1
    req_valid = '0;
    repeat (6) tick();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    nacc = 0;
    repeat (10) begin
      @(negedge clk);
      if (req_ready != '0) nacc++;
    end
    chk("t3_accepts", nacc, DEPTH);
    chk("t3_stalled", 32'(req_ready), 0);
    tick();
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_drain_valid", 32'(rsp_valid), 1);
      chk("t3_drain_id", 32'(rsp_id), 1);
      if (k == 0) chk("t3_full_ready", 32'(req_ready), 0);
      if (k == 1) chk("t3_resume", 32'(req_ready), 32'h2);
    end
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      req_valid = 4'($urandom);
      rand_ops();
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Reset with operations in flight
    req_valid = '0; rsp_ready = 1'b1;
    repeat (8) tick();
    req_valid = 4'b0100;
    rand_ops();
    tick();
    tick();
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("t5_rsp_valid", 32'(rsp_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_op_count", 32'(op_count), 0);
    chk("t5_mul_a", 32'(mul_a), 0);
    chk("t5_rsp_p", 32'(rsp_p), 0);
    tick();
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t5_quiet", 32'(rsp_valid), 0);
    end
    tick();
    req_valid = 4'hF;
    @(negedge clk);
    chk("t5_rr_restart", 32'(req_ready), 32'h1);

    // Counter wrap after 65536 accepts
    nacc = 1;
    for (int c = 0; c < 70000 && nacc < 65535; c++) begin
      @(negedge clk);
      if (req_ready != '0) nacc++;
    end
    chk("t6_budget", nacc, 65535);
    @(negedge clk);
    chk("t6_ffff", 32'(op_count), 32'hFFFF);
    chk("t6_accept", 32'(req_ready != '0), 1);
    @(negedge clk);
    chk("t6_wrap", 32'(op_count), 0);

    tick();
    req_valid = '0;
    repeat (6) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
